// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: state encoding,
// instruction width and the NOP word presented while no instruction is held.
package fetch_pkg;

  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    ISSUE = 2'd1,
    ERROR = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_watchdog.sv
// Wait-state watchdog for the fetch stage. Counts cycles in which a fetch
// request is outstanding and unacknowledged; timeout_o fires in the cycle
// whose increment would reach MAX_WAIT. MAX_WAIT = 0 disables the timeout.
module fetch_watchdog
  import fetch_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic timeout_o
);

  localparam int unsigned CW = (MAX_WAIT == 0) ? 1 : $clog2(MAX_WAIT + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [CW-1:0] cnt_inc;

  assign cnt_inc = cnt_q + CW'(1);

  // Next count: clear wins over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_inc;
    end
  end

  // Wait counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout_o = (MAX_WAIT != 0) && en_i && !clr_i && (cnt_inc == CW'(MAX_WAIT));

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches words over a req/ack
// handshake that tolerates wait states, and hands each instruction to
// decode with a valid/ready handshake. Retiring advances the PC by 4 or
// loads a word-aligned branch target.
// Optional build macro FETCH_PERF_EN adds perf_retired / perf_stall counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [31:0]        imem_addr,
  output logic               imem_req,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               pc_load,
  input  logic [31:0]        pc_target,
  output logic [31:0]        pc,
  output logic [31:0]        pc_plus4,
  output logic [31:0]        pc_plus8,
  output logic               fetch_err
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_retired,
  output logic [31:0]        perf_stall
`endif
);

  fetch_state_e       state_q;
  logic [31:0]        pc_q;
  logic               req_q;
  logic               valid_q;
  logic               err_q;
  logic [INSTR_W-1:0] instr_q;

  logic        fetching;
  logic        stall;
  logic        retire;
  logic        wd_timeout;
  logic [31:0] pc_next;

  // The first cycle after reset is idle (req not yet raised), so only
  // cycles with the request actually on the bus count as fetch cycles.
  assign fetching = (state_q == FETCH) && req_q;
  assign stall    = fetching && !imem_ack;
  assign retire   = valid_q && instr_ready;

  assign pc_plus4 = pc_q + 32'd4;
  assign pc_plus8 = pc_q + 32'd8;
  assign pc_next  = pc_load ? (pc_target & ~32'h3) : pc_plus4;

  fetch_watchdog #(
    .MAX_WAIT (MAX_WAIT)
  ) u_watchdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (retire),
    .en_i      (stall),
    .timeout_o (wd_timeout)
  );

  // Fetch FSM with registered handshake outputs and PC update at retire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      instr_q <= NOP;
    end else begin
      case (state_q)
        FETCH: begin
          if (!req_q) begin
            req_q <= 1'b1;
          end else if (imem_ack) begin
            instr_q <= imem_rdata;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
            state_q <= ISSUE;
          end else if (wd_timeout) begin
            req_q   <= 1'b0;
            err_q   <= 1'b1;
            state_q <= ERROR;
          end
        end
        ISSUE: begin
          if (instr_ready) begin
            pc_q    <= pc_next;
            valid_q <= 1'b0;
            req_q   <= 1'b1;
            state_q <= FETCH;
          end
        end
        ERROR: begin
          req_q   <= 1'b0;
          valid_q <= 1'b0;
          err_q   <= 1'b1;
        end
        default: begin
          state_q <= ERROR;
        end
      endcase
    end
  end

  assign imem_addr   = pc_q;
  assign imem_req    = req_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign fetch_err   = err_q;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_retired_q;
  logic [31:0] perf_stall_q;

  // Free-running event counters, wrapping mod 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_retired_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      if (retire) perf_retired_q <= perf_retired_q + 32'd1;
      if (stall)  perf_stall_q   <= perf_stall_q + 32'd1;
    end
  end

  assign perf_retired = perf_retired_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule
